// File: rtl/accbuf_wr_arbiter.sv
// accbuf_wr_arbiter: funnels the per-channel mix/accumulate results into the
// single accumulation-buffer write port. Each channel owns a small FIFO and a
// private write pointer inside its own address region. Non-empty FIFOs are
// drained round-robin, one buffer write per cycle.
//
// Handshake: the requesters have no ready. An in_valid pulse is a one-cycle
// offer that is either stored in the channel FIFO or dropped (which sets the
// sticky overflow bit). The buffer side has no ready either: we=1 means
// addr/data are written at that cycle, unconditionally.
module accbuf_wr_arbiter #(
  parameter int NCHAN      = 4,
  parameter int DATAWIDTH  = 64,
  parameter int ADDRWIDTH  = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       resetacc,
  input  logic [NCHAN-1:0]           in_valid,
  input  logic [NCHAN*DATAWIDTH-1:0] in_data,
  output logic                       we,
  output logic [ADDRWIDTH-1:0]       addr,
  output logic [DATAWIDTH-1:0]       data,
  output logic [NCHAN-1:0]           overflow,
  output logic [NCHAN-1:0]           wrapped,
  output logic                       busy
);

  localparam int CW = $clog2(NCHAN);
  localparam int PW = ADDRWIDTH - CW;
  localparam int FW = $clog2(FIFO_DEPTH);

  // Per-channel FIFO storage and bookkeeping.
  logic [DATAWIDTH-1:0] mem    [NCHAN][FIFO_DEPTH];
  logic [FW-1:0]        rd_idx [NCHAN];
  logic [FW-1:0]        wr_idx [NCHAN];
  logic [FW:0]          count  [NCHAN];
  logic [PW-1:0]        ptr    [NCHAN];

  logic [CW-1:0]    last_grant;
  logic             grant_valid;
  logic [CW-1:0]    grant;
  logic [CW-1:0]    cand;
  logic [NCHAN-1:0] nonempty;
  logic [NCHAN-1:0] pop;
  logic [NCHAN-1:0] push_ok;

  // Occupancy flags come from registered counts only, so a word pushed this
  // edge becomes grantable one cycle later (no bypass path).
  always_comb begin
    for (int i = 0; i < NCHAN; i++) begin
      nonempty[i] = (count[i] != '0);
    end
  end

  // Round-robin search: offsets are scanned from largest to smallest so the
  // channel closest above last_grant is the one left standing. Offset NCHAN
  // truncates to last_grant itself, which therefore has the lowest priority.
  always_comb begin
    grant_valid = 1'b0;
    grant       = last_grant;
    cand        = last_grant;
    for (int k = NCHAN; k >= 1; k--) begin
      cand = last_grant + CW'(k);
      if (nonempty[cand]) begin
        grant_valid = 1'b1;
        grant       = cand;
      end
    end
  end

  // Pop follows the grant; a push is accepted when there is room, counting
  // the slot freed by a same-edge pop. resetacc discards both.
  always_comb begin
    for (int i = 0; i < NCHAN; i++) begin
      pop[i]     = grant_valid && (grant == CW'(i)) && !resetacc;
      push_ok[i] = in_valid[i] && !resetacc &&
                   ((count[i] != (FW+1)'(FIFO_DEPTH)) || pop[i]);
    end
  end

  // FIFO storage write; contents need no reset because count gates reads.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCHAN; i++) begin
      if (push_ok[i]) begin
        mem[i][wr_idx[i]] <= in_data[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  // FIFO indices, pointers, sticky flags and the registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCHAN; i++) begin
        rd_idx[i] <= '0;
        wr_idx[i] <= '0;
        count[i]  <= '0;
        ptr[i]    <= '0;
      end
      overflow   <= '0;
      wrapped    <= '0;
      last_grant <= CW'(NCHAN - 1);
      we         <= 1'b0;
      addr       <= '0;
      data       <= '0;
    end else if (resetacc) begin
      for (int i = 0; i < NCHAN; i++) begin
        rd_idx[i] <= '0;
        wr_idx[i] <= '0;
        count[i]  <= '0;
        ptr[i]    <= '0;
      end
      overflow   <= '0;
      wrapped    <= '0;
      last_grant <= CW'(NCHAN - 1);
      we         <= 1'b0;
    end else begin
      for (int i = 0; i < NCHAN; i++) begin
        if (pop[i]) begin
          rd_idx[i] <= rd_idx[i] + FW'(1);
        end
        if (push_ok[i]) begin
          wr_idx[i] <= wr_idx[i] + FW'(1);
        end
        if (push_ok[i] && !pop[i]) begin
          count[i] <= count[i] + (FW+1)'(1);
        end else if (!push_ok[i] && pop[i]) begin
          count[i] <= count[i] - (FW+1)'(1);
        end
        if (in_valid[i] && !push_ok[i]) begin
          overflow[i] <= 1'b1;
        end
      end
      we <= grant_valid;
      if (grant_valid) begin
        addr        <= {grant, ptr[grant]};
        data        <= mem[grant][rd_idx[grant]];
        ptr[grant]  <= ptr[grant] + PW'(1);
        last_grant  <= grant;
        if (&ptr[grant]) begin
          wrapped[grant] <= 1'b1;
        end
      end
    end
  end

  // Activity indicator for the surrounding control logic.
  assign busy = (|nonempty) | we;

endmodule
